// File: rtl/sl_vpos_gen.sv
// Scanline vertical-position generator: delays the video stream by one cycle and
// tags each output line with its relative position inside its source line.
module sl_vpos_gen #(
    parameter int         COLOR_W  = 8,
    parameter logic [9:0] STEP_MIN = 10'h020,
    parameter logic [9:0] STEP_MAX = 10'h100
) (
    input  logic                   VCLK_i,
    input  logic                   nVRST_i,
    input  logic                   HSYNC_i,
    input  logic                   VSYNC_i,
    input  logic                   DE_i,
    input  logic [3*COLOR_W-1:0]   vdata_i,
    input  logic [9:0]             v_step_i,
    input  logic [7:0]             v_phase_init_i,
    input  logic                   sl_en_i,
    output logic                   HSYNC_o,
    output logic                   VSYNC_o,
    output logic                   DE_o,
    output logic [3*COLOR_W-1:0]   vdata_o,
    output logic [7:0]             sl_rel_pos_o,
    output logic                   sl_en_o,
    output logic [10:0]            in_line_cnt_o
);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        WAIT_LINE  = 2'd1,
        IN_LINE    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  acc_q, acc_d;
    logic [9:0]  step_sh_q, step_sh_d;
    logic        sl_en_sh_q, sl_en_sh_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic [7:0]  rel_pos_d;
    logic [10:0] line_cnt_out_d;
    logic        sl_en_d;

    logic [9:0]  step_clamped;
    logic [9:0]  sum;
    logic [11:0] cnt_sum;
    logic [10:0] cnt_sat;

    // The delayed video outputs double as the registered copies for edge detection.
    logic vs_start, de_rise, de_fall;
    assign vs_start = VSYNC_o & ~VSYNC_i;
    assign de_rise  = ~DE_o & DE_i;
    assign de_fall  = DE_o & ~DE_i;

    always_ff @(posedge VCLK_i or negedge nVRST_i) begin
        if (!nVRST_i) begin
            HSYNC_o <= 1'b0;
            VSYNC_o <= 1'b0;
            DE_o    <= 1'b0;
            vdata_o <= '0;
        end else begin
            HSYNC_o <= HSYNC_i;
            VSYNC_o <= VSYNC_i;
            DE_o    <= DE_i;
            vdata_o <= vdata_i;
        end
    end

    always_ff @(posedge VCLK_i or negedge nVRST_i) begin
        if (!nVRST_i) begin
            state_q       <= WAIT_FRAME;
            acc_q         <= '0;
            step_sh_q     <= '0;
            sl_en_sh_q    <= 1'b0;
            line_cnt_q    <= '0;
            sl_rel_pos_o  <= '0;
            in_line_cnt_o <= '0;
            sl_en_o       <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            step_sh_q     <= step_sh_d;
            sl_en_sh_q    <= sl_en_sh_d;
            line_cnt_q    <= line_cnt_d;
            sl_rel_pos_o  <= rel_pos_d;
            in_line_cnt_o <= line_cnt_out_d;
            sl_en_o       <= sl_en_d;
        end
    end

    // Frame start wins over any line event in the same cycle.
    always_comb begin
        state_d = state_q;
        if (vs_start) begin
            state_d = WAIT_LINE;
        end else begin
            case (state_q)
                WAIT_LINE: if (de_rise) state_d = IN_LINE;
                IN_LINE:   if (de_fall) state_d = WAIT_LINE;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        if (v_step_i < STEP_MIN)      step_clamped = STEP_MIN;
        else if (v_step_i > STEP_MAX) step_clamped = STEP_MAX;
        else                          step_clamped = v_step_i;

        sum     = {2'b00, acc_q} + step_sh_q;
        cnt_sum = {1'b0, line_cnt_q} + {10'b0, sum[9:8]};
        cnt_sat = cnt_sum[11] ? 11'h7FF : cnt_sum[10:0];

        acc_d          = acc_q;
        step_sh_d      = step_sh_q;
        sl_en_sh_d     = sl_en_sh_q;
        line_cnt_d     = line_cnt_q;
        rel_pos_d      = sl_rel_pos_o;
        line_cnt_out_d = in_line_cnt_o;

        if (vs_start) begin
            step_sh_d      = step_clamped;
            sl_en_sh_d     = sl_en_i;
            acc_d          = v_phase_init_i;
            line_cnt_d     = '0;
            rel_pos_d      = v_phase_init_i;
            line_cnt_out_d = '0;
        end else begin
            case (state_q)
                WAIT_LINE: begin
                    if (de_rise) begin
                        rel_pos_d      = acc_q;
                        line_cnt_out_d = line_cnt_q;
                    end
                end
                IN_LINE: begin
                    if (de_fall) begin
                        acc_d      = sum[7:0];
                        line_cnt_d = cnt_sat;
                    end
                end
                default: ;
            endcase
        end

        sl_en_d = (state_d != WAIT_FRAME) && sl_en_sh_d;
    end

endmodule
